ex_commit_ctrl: RTL and testbench

//  Exception/interrupt/ertn commit sequencer, placed beside wb_stage. Picks one event per

---
 rtl/ex_commit_ctrl_pkg.sv | 19 +
 rtl/ex_commit_ctrl.sv | 110 +++++++++++
 tb/tb_ex_commit_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_commit_ctrl_pkg.sv
// rtl/ex_commit_ctrl_pkg.sv - shared encodings for the exception/ertn commit sequencer
package ex_commit_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COMMIT   = 2'd1,
        S_FLUSH    = 2'd2,
        S_REDIRECT = 2'd3
    } cc_state_e;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam int         REDIRECT_W = 32;

    // IF fetches word-aligned, so the low two bits of any target are dropped.
    function automatic logic [REDIRECT_W-1:0] align_pc(input logic [REDIRECT_W-1:0] pc);
        return {pc[REDIRECT_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ex_commit_ctrl.sv
// rtl/ex_commit_ctrl.sv - commits one interrupt/exception/ertn, flushes, then redirects IF
module ex_commit_ctrl
    import ex_commit_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ws_valid,
    input  logic                  ws_ex,
    input  logic [5:0]            ws_ecode,
    input  logic [8:0]            ws_esubcode,
    input  logic                  ws_ertn,
    input  logic [31:0]           ws_pc,
    input  logic                  has_int,
    input  logic [31:0]           csr_eentry,
    input  logic [31:0]           csr_era,
    input  logic                  fs_redirect_ready,
    output logic                  busy,
    output logic                  flush_pipe,
    output logic                  csr_ex_commit,
    output logic                  csr_ertn_commit,
    output logic [5:0]            csr_ecode,
    output logic [8:0]            csr_esubcode,
    output logic [31:0]           csr_epc,
    output logic                  redirect_valid,
    output logic [31:0]           redirect_pc,
    output logic [CNT_W-1:0]      ev_count
);

    localparam int TMR_W = $clog2(FLUSH_CYCLES + 1);

    cc_state_e          state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               is_ex_q;
    logic [5:0]         ecode_q;
    logic [8:0]         esub_q;
    logic [31:0]        epc_q;
    logic [31:0]        target_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ev;
    logic               take_ex;

    // Younger events are ignored outside IDLE: they are being flushed anyway.
    assign ev      = ws_valid & (has_int | ws_ex | ws_ertn) & (state_q == S_IDLE);
    assign take_ex = has_int | ws_ex;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                if (ev) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                // The commit cycle itself is the first flush cycle.
                timer_d = TMR_W'(FLUSH_CYCLES - 1);
                state_d = (FLUSH_CYCLES == 1) ? S_REDIRECT : S_FLUSH;
            end
            S_FLUSH: begin
                timer_d = timer_q - TMR_W'(1);
                if (timer_q <= TMR_W'(1)) state_d = S_REDIRECT;
            end
            S_REDIRECT: begin
                if (fs_redirect_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy            = (state_q != S_IDLE) | ev;
        flush_pipe      = (state_q != S_IDLE);
        csr_ex_commit   = (state_q == S_COMMIT) & is_ex_q;
        csr_ertn_commit = (state_q == S_COMMIT) & ~is_ex_q;
        redirect_valid  = (state_q == S_REDIRECT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            is_ex_q  <= 1'b0;
            ecode_q  <= '0;
            esub_q   <= '0;
            epc_q    <= '0;
            target_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (ev) begin
                is_ex_q  <= take_ex;
                ecode_q  <= has_int ? ECODE_INT : ws_ecode;
                esub_q   <= has_int ? 9'd0 : ws_esubcode;
                epc_q    <= ws_pc;
                target_q <= take_ex ? csr_eentry : csr_era;
            end
            if (state_q == S_COMMIT) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign csr_ecode    = ecode_q;
    assign csr_esubcode = esub_q;
    assign csr_epc      = epc_q;
    assign redirect_pc  = align_pc(target_q);
    assign ev_count     = cnt_q;

endmodule

// File: tb/tb_ex_commit_ctrl.sv
// tb/tb_ex_commit_ctrl.sv - self-checking bench for ex_commit_ctrl with cycle-offset reference model
module tb_ex_commit_ctrl;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ws_valid = 1'b0, ws_ex = 1'b0, ws_ertn = 1'b0, has_int = 1'b0;
    logic [5:0]  ws_ecode = '0;
    logic [8:0]  ws_esubcode = '0;
    logic [31:0] ws_pc = '0, csr_eentry = '0, csr_era = '0;
    logic        fs_redirect_ready = 1'b0;
    logic        busy, flush_pipe, csr_ex_commit, csr_ertn_commit, redirect_valid;
    logic [5:0]  csr_ecode;
    logic [8:0]  csr_esubcode;
    logic [31:0] csr_epc, redirect_pc, ev_count;

    int checks = 0;
    int errors = 0;

    ex_commit_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .ws_valid(ws_valid), .ws_ex(ws_ex), .ws_ecode(ws_ecode), .ws_esubcode(ws_esubcode),
        .ws_ertn(ws_ertn), .ws_pc(ws_pc), .has_int(has_int),
        .csr_eentry(csr_eentry), .csr_era(csr_era), .fs_redirect_ready(fs_redirect_ready),
        .busy(busy), .flush_pipe(flush_pipe), .csr_ex_commit(csr_ex_commit),
        .csr_ertn_commit(csr_ertn_commit), .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode),
        .csr_epc(csr_epc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ev_count(ev_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Model: a sequence is described only by the number of cycles since its event cycle.
    bit          started = 0;
    bit          m_active = 0;
    int          m_off = 0;
    bit          m_is_ex = 0;
    logic [5:0]  m_ecode = '0;
    logic [8:0]  m_esub = '0;
    logic [31:0] m_epc = '0, m_tgt = '0, m_cnt = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_active = 0;
            m_cnt    = '0;
            started  = 1;
        end else if (started) begin
            if (!m_active) begin
                if (ws_valid && (has_int || ws_ex || ws_ertn)) begin
                    m_active = 1;
                    m_off    = 1;
                    m_is_ex  = has_int || ws_ex;
                    m_ecode  = has_int ? 6'h00 : ws_ecode;
                    m_esub   = has_int ? 9'h000 : ws_esubcode;
                    m_epc    = ws_pc;
                    m_tgt    = m_is_ex ? csr_eentry : csr_era;
                end
            end else begin
                if (m_off == 1) m_cnt = m_cnt + 32'd1;
                if (m_off >= 1 + FC && fs_redirect_ready) m_active = 0;
                else m_off++;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            bit ev, e_str, e_rv;
            ev    = ws_valid && (has_int || ws_ex || ws_ertn);
            e_str = m_active && m_off == 1;
            e_rv  = m_active && m_off >= 1 + FC;
            chk("busy", busy, m_active ? 1 : ev);
            chk("flush_pipe", flush_pipe, m_active);
            chk("csr_ex_commit", csr_ex_commit, e_str && m_is_ex);
            chk("csr_ertn_commit", csr_ertn_commit, e_str && !m_is_ex);
            chk("redirect_valid", redirect_valid, e_rv);
            chk("ev_count", ev_count, m_cnt);
            if (e_str && m_is_ex) begin
                chk("csr_ecode", csr_ecode, m_ecode);
                chk("csr_esubcode", csr_esubcode, m_esub);
                chk("csr_epc", csr_epc, m_epc);
            end
            if (e_rv) chk("redirect_pc", redirect_pc, {m_tgt[31:2], 2'b00});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ws();
        ws_valid = 0; ws_ex = 0; ws_ertn = 0; has_int = 0;
    endtask

    // Finish an offered redirect: wait (bounded) for the offer, then handshake once.
    task automatic finish_redirect(input string nm);
        int n = 0;
        @(negedge clk);
        while (!redirect_valid && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        chk({nm, "_offer_seen"}, redirect_valid, 1'b1);
        fs_redirect_ready = 1;
        tick();
        fs_redirect_ready = 0;
    endtask

    initial begin
        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_flush", flush_pipe, 0);
        chk("rst_rv", redirect_valid, 0);
        chk("rst_cnt", ev_count, 0);
        chk("rst_pc", redirect_pc, 0);
        tick();
        reset = 0;
        tick();

        // Exception with full latency pinned.
        ws_valid = 1; ws_ex = 1; ws_ecode = 6'h0B; ws_esubcode = 9'h000;
        ws_pc = 32'h1c000100; csr_eentry = 32'h1c008000; csr_era = 32'h1c00abc0;
        @(negedge clk); chk("t1_busy_N", busy, 1);
        tick(); clear_ws();
        @(negedge clk);
        chk("t1_strobe", csr_ex_commit, 1);
        chk("t1_ecode", csr_ecode, 6'h0B);
        chk("t1_epc", csr_epc, 32'h1c000100);
        tick(); @(negedge clk);
        chk("t1_rv_N2", redirect_valid, 0);
        chk("t1_cnt", ev_count, 1);
        tick(); @(negedge clk);
        chk("t1_rv_N3", redirect_valid, 1);
        chk("t1_rpc", redirect_pc, 32'h1c008000);
        fs_redirect_ready = 1;
        tick(); fs_redirect_ready = 0;
        @(negedge clk); chk("t1_idle", busy, 0);

        // ertn.
        tick();
        ws_valid = 1; ws_ertn = 1; csr_era = 32'h1c000104;
        tick(); clear_ws();
        @(negedge clk);
        chk("t2_ertn", csr_ertn_commit, 1);
        chk("t2_noex", csr_ex_commit, 0);
        tick(); tick(); @(negedge clk);
        chk("t2_rpc", redirect_pc, 32'h1c000104);
        finish_redirect("t2");

        // Interrupt beats ertn.
        tick();
        ws_valid = 1; ws_ertn = 1; has_int = 1; ws_ecode = 6'h15;
        csr_eentry = 32'h1c008000; csr_era = 32'h1c0000f0;
        tick(); clear_ws();
        @(negedge clk);
        chk("t3_ex", csr_ex_commit, 1);
        chk("t3_noertn", csr_ertn_commit, 0);
        chk("t3_ecode", csr_ecode, 6'h00);
        tick(); tick(); @(negedge clk);
        chk("t3_rpc", redirect_pc, 32'h1c008000);
        finish_redirect("t3");

        // IF stalls the redirect for 5 cycles.
        tick();
        ws_valid = 1; ws_ex = 1; ws_ecode = 6'h08; ws_pc = 32'h1c000200;
        csr_eentry = 32'h1c00c003;
        tick(); clear_ws();
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_rv_hold", redirect_valid, 1);
            chk("t4_busy_hold", busy, 1);
            chk("t4_flush_hold", flush_pipe, 1);
            chk("t4_rpc_hold", redirect_pc, 32'h1c00c000);
            tick();
        end
        finish_redirect("t4");

        // Second exception during FLUSH is ignored.
        tick();
        ws_valid = 1; ws_ex = 1; ws_ecode = 6'h01;
        tick(); clear_ws();
        tick();
        ws_valid = 1; ws_ex = 1; ws_ecode = 6'h02;
        tick(); clear_ws();
        finish_redirect("t5");
        repeat (3) tick();
        @(negedge clk);
        chk("t5_cnt", ev_count, 5);
        chk("t5_idle", busy, 0);

        // Reset during FLUSH, then a normal sequence.
        ws_valid = 1; ws_ex = 1;
        tick(); clear_ws();
        tick();
        reset = 1;
        tick();
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_flush", flush_pipe, 0);
        chk("t6_ex", csr_ex_commit, 0);
        chk("t6_rv", redirect_valid, 0);
        chk("t6_cnt", ev_count, 0);
        reset = 0;
        tick();
        ws_valid = 1; ws_ex = 1; ws_ecode = 6'h0C;
        tick(); clear_ws();
        finish_redirect("t6");
        @(negedge clk);
        chk("t6_cnt_after", ev_count, 1);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            tick();
            reset             = ($urandom_range(0, 299) == 0);
            ws_valid          = ($urandom_range(0, 1) == 1);
            ws_ex             = ($urandom_range(0, 3) == 0);
            ws_ertn           = ($urandom_range(0, 3) == 0);
            has_int           = ($urandom_range(0, 9) == 0);
            ws_ecode          = 6'($urandom);
            ws_esubcode       = 9'($urandom);
            ws_pc             = $urandom;
            csr_eentry        = $urandom;
            csr_era           = $urandom;
            fs_redirect_ready = ($urandom_range(0, 1) == 1);
        end
        tick();
        reset = 0; clear_ws(); fs_redirect_ready = 1;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
